// File: rtl/alu_serial_seq.sv
// -----------------------------------------------------------------------------
// alu_serial_seq
//   Bit-serial ALU sequencer. An operation (op_a, op_b, alu_sel) is accepted
//   over a valid/ready handshake and then processed LSB-first, one bit per
//   clock, through a single-bit ALU slice (a, b, carry-in, invert, sel). The
//   per-bit results are collected into a WIDTH-bit result, and set-less-than
//   gets one extra fix-up cycle. The result and its flags are then presented
//   on a valid/ready output handshake.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operation request valid
//   in_ready   out  1      sequencer can accept an operation (IDLE only)
//   op_a       in   WIDTH  operand A
//   op_b       in   WIDTH  operand B
//   alu_sel    in   3      000 and, 001 or, 010 add, 110 sub, 111 slt
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  operation result
//   carry_out  out  1      carry out of MSB (add/sub/slt), else 0
//   overflow   out  1      signed overflow (add/sub/slt), else 0
//   zero       out  1      result == 0
// -----------------------------------------------------------------------------
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLT_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers: bit i of each operand sits in position 0 during
  // RUN cycle i, so the slice always reads bit 0.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;          // running carry between bit slices
  logic             cin_msb_q;    // carry into the MSB slice
  logic             cout_msb_q;   // carry out of the MSB slice
  logic             out_valid_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;

  // ---------------------------------------------------------------------------
  // Single-bit ALU slice
  // ---------------------------------------------------------------------------
  logic invert_in;
  logic invert;
  logic b_eff;
  logic sum_bit;
  logic cout_bit;
  logic res_bit;
  logic is_arith;
  logic is_last;
  logic less;

  assign invert_in = (alu_sel == SEL_SUB) || (alu_sel == SEL_SLT);
  assign invert    = (sel_q == SEL_SUB) || (sel_q == SEL_SLT);
  assign b_eff     = b_q[0] ^ invert;
  assign sum_bit   = a_q[0] ^ b_eff ^ c_q;
  assign cout_bit  = (a_q[0] & b_eff) | (a_q[0] & c_q) | (b_eff & c_q);
  assign is_arith  = (sel_q == SEL_ADD) || invert;
  assign is_last   = (cnt_q == LAST_CNT);

  // Sign of the difference corrected by overflow gives the true signed compare.
  assign less = res_q[WIDTH-1] ^ (cin_msb_q ^ cout_msb_q);

  always_comb begin
    res_bit = 1'b0;
    case (sel_q)
      SEL_AND: res_bit = a_q[0] & b_q[0];
      SEL_OR:  res_bit = a_q[0] | b_q[0];
      SEL_ADD,
      SEL_SUB,
      SEL_SLT: res_bit = sum_bit;
      default: res_bit = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (is_last) begin
          state_d = (sel_q == SEL_SLT) ? S_SLT_FIX : S_DONE;
        end
      end
      S_SLT_FIX: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // The first DONE cycle registers the flags; the handshake is only
        // honoured once out_valid is actually visible.
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cin_msb_q   <= 1'b0;
      cout_msb_q  <= 1'b0;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sel_q <= alu_sel;
            c_q   <= invert_in;   // +1 of the two's complement for sub/slt
            cnt_q <= '0;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          // After WIDTH shifts the bit produced in cycle i lands in res_q[i].
          res_q <= {res_bit, res_q[WIDTH-1:1]};
          c_q   <= cout_bit;
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_last) begin
            cin_msb_q  <= c_q;
            cout_msb_q <= cout_bit;
          end
        end
        S_SLT_FIX: begin
          res_q <= WIDTH'(less);
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            carry_out_q <= is_arith & cout_msb_q;
            overflow_q  <= is_arith & (cin_msb_q ^ cout_msb_q);
            zero_q      <= ~|res_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_seq
//   Directed bench for the bit-serial ALU sequencer. A monitor on the falling
//   edge compares every valid output cycle against an arithmetic model of the
//   operation, checks latency and handshake behaviour, and also checks the
//   hand-computed literal expectation attached to each directed vector.
// -----------------------------------------------------------------------------
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   alu_sel = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    int           lat;
    int           acc;
  } exp_t;

  typedef struct {
    bit           has;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } lit_t;

  exp_t exp_q[$];
  lit_t lit_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour in plain arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] s, output logic [W-1:0] r,
                                output logic c, output logic v, output logic z);
    logic [W:0] t;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    t = '0;
    case (s)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[W-1:0];
        c = t[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'b110, 3'b111: begin
        t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r = t[W-1:0];
        c = t[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        if (s == 3'b111) r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / compare process
  // ---------------------------------------------------------------------------
  logic         prev_ov = 1'b0;
  logic         prev_hs = 1'b0;
  exp_t         e_cur;
  exp_t         e_new;
  lit_t         l_cur;
  logic [W-1:0] m_r;
  logic         m_c, m_v, m_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lit_q.delete();
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("in_ready_after_release", in_ready, 1);
        chk("out_valid_drop", out_valid, 0);
      end else if (prev_ov) begin
        chk("out_valid_hold", out_valid, 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          e_cur = exp_q[0];
          if (!prev_ov) chk("latency", W'(cyc - e_cur.acc), W'(e_cur.lat));
          chk("result", result, e_cur.r);
          chk("carry_out", carry_out, e_cur.c);
          chk("overflow", overflow, e_cur.v);
          chk("zero", zero, e_cur.z);
          chk("in_ready_busy", in_ready, 0);
          if (!prev_ov && lit_q.size() > 0) begin
            l_cur = lit_q[0];
            if (l_cur.has) begin
              chk("lit_result", result, l_cur.r);
              chk("lit_flags", {29'd0, carry_out, overflow, zero}, {29'd0, l_cur.c, l_cur.v, l_cur.z});
            end
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (lit_q.size() > 0) void'(lit_q.pop_front());
          end
        end
      end
      prev_hs = out_valid && out_ready;
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        model(op_a, op_b, alu_sel, m_r, m_c, m_v, m_z);
        e_new.r   = m_r;
        e_new.c   = m_c;
        e_new.v   = m_v;
        e_new.z   = m_z;
        e_new.lat = (alu_sel == 3'b111) ? W + 2 : W + 1;
        e_new.acc = cyc + 1;
        exp_q.push_back(e_new);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit has, input logic [W-1:0] lr,
                       input logic lc, input logic lv, input logic lz);
    lit_t l;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    l.has = has; l.r = lr; l.c = lc; l.v = lv; l.z = lz;
    lit_q.push_back(l);
    op_a = a; op_b = b; alu_sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Garbage outside the accepting cycle must be ignored.
    op_a = $urandom; op_b = $urandom; alu_sel = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", W'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors with hand-computed literals
    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 0, 1, 0); wait_idle();
    issue(3'b110, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1, 0, 1); wait_idle();
    issue(3'b111, 32'hFFFF_FFFD, 32'h0000_0005, 1, 32'h0000_0001, 1, 0, 0); wait_idle();
    issue(3'b111, 32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 1, 1, 0); wait_idle();
    issue(3'b111, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1, 0, 1); wait_idle();
    issue(3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'h00F0_000F, 0, 0, 0); wait_idle();
    issue(3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1, 32'hFFF0_0FFF, 0, 0, 0); wait_idle();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 0, 1); wait_idle();
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1, 0, 1);
    issue(3'b110, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 0, 0, 0);
    issue(3'b111, 32'h0000_0001, 32'h8000_0000, 1, 32'h0000_0000, 0, 1, 1);
    issue(3'b101, 32'h1234_5678, 32'h0000_0000, 1, 32'h0000_0000, 0, 0, 1);
    wait_idle();

    // Backpressure: result held, in_valid pulses ignored
    out_ready = 1'b0;
    issue(3'b010, 32'h1234_5678, 32'h1111_1111, 1, 32'h2345_6789, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      op_a = $urandom; op_b = $urandom; alu_sel = 3'b010;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    issue(3'b110, 32'h0000_0010, 32'h0000_0003, 1, 32'h0000_000D, 1, 0, 0); wait_idle();

    // Reset in the middle of RUN aborts the operation
    issue(3'b010, 32'h0000_1000, 32'h0000_2000, 0, '0, 0, 0, 0);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (40) @(posedge clk);
    #1;
    issue(3'b010, 32'h0000_0003, 32'h0000_0004, 1, 32'h0000_0007, 0, 0, 0); wait_idle();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
